// File: rtl/adder_share_arbiter_if.sv
// Requester-side and shared-adder signals of adder_share_arbiter.
// slave is the arbiter's view; master is the requester/adder side.
interface adder_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 9
) ();
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [W:0]        rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      add_in0;
  logic [W-1:0]      add_in1;
  logic [W:0]        add_out;

  modport slave (
    input  req, req_a, req_b, add_out,
    output gnt, rsp_valid, rsp_sum, rsp_id, add_in0, add_in1
  );

  modport master (
    output req, req_a, req_b, add_out,
    input  gnt, rsp_valid, rsp_sum, rsp_id, add_in0, add_in1
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer time-sharing one W-bit adder among NREQ requesters;
// operands are held for ADD_LAT cycles, then the sum returns with a one-cycle pulse.
//
// state  | meaning
// S_IDLE | arbitrate among req, latch winner's operands on the grant edge
// S_WAIT | operands held on the adder, counter runs down to 0
// S_DONE | rsp_valid pulse for the owner of rsp_sum
module adder_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 1,
  parameter int W       = 9
) (
  input  logic                  clk,
  input  logic                  resetn,
  adder_share_arbiter_if.slave  bus,
  output logic                  busy
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   ptr_next;
  logic [IDW-1:0]   win;
  logic             win_valid;
  logic [IDW:0]     idx;
  logic [CW-1:0]    cnt_q;
  logic [W-1:0]     add_in0_q;
  logic [W-1:0]     add_in1_q;
  logic [W:0]       rsp_sum_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [NREQ-1:0]  gnt_c;
  logic [NREQ-1:0]  rsp_valid_c;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Search upward from rr_ptr with wrap; first set bit wins.
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NREQ)) begin
        idx = idx - (IDW+1)'(NREQ);
      end
      if (!win_valid && bus.req[idx[IDW-1:0]]) begin
        win_valid = 1'b1;
        win       = idx[IDW-1:0];
      end
    end
    ptr_next = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_valid) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The counter still holds its load value only in the first WAIT cycle.
  always_comb begin
    gnt_c       = '0;
    rsp_valid_c = '0;
    busy        = (state_q != S_IDLE);
    if (state_q == S_WAIT && cnt_q == CW'(ADD_LAT - 1)) begin
      gnt_c[rsp_id_q] = 1'b1;
    end
    if (state_q == S_DONE) begin
      rsp_valid_c[rsp_id_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      add_in0_q <= '0;
      add_in1_q <= '0;
      rsp_sum_q <= '0;
      rsp_id_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            add_in0_q <= bus.req_a[win*W +: W];
            add_in1_q <= bus.req_b[win*W +: W];
            rsp_id_q  <= win;
            rr_ptr_q  <= ptr_next;
            cnt_q     <= CW'(ADD_LAT - 1);
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            rsp_sum_q <= bus.add_out;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.add_in0   = add_in0_q;
  assign bus.add_in1   = add_in1_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: one instance with ADD_LAT=1, one with ADD_LAT=3,
// checked against a transaction-level round-robin model.
module tb_adder_share_arbiter;
  logic clk = 1'b0;
  logic resetn;
  logic busy1;
  logic busy3;
  int   checks = 0;
  int   errors = 0;
  int   ptr[2];
  logic [9:0] pipe1;
  logic [9:0] pipe2;

  adder_share_arbiter_if #(.NREQ(4), .W(9)) if1 ();
  adder_share_arbiter_if #(.NREQ(4), .W(9)) if3 ();

  always #5 clk = ~clk;

  // Single-cycle adder for dut1; three-cycle adder for dut3 whose output is
  // stale until inputs have been stable for three cycles.
  assign if1.add_out = {1'b0, if1.add_in0} + {1'b0, if1.add_in1};
  always @(posedge clk) begin
    pipe1 <= {1'b0, if3.add_in0} + {1'b0, if3.add_in1};
    pipe2 <= pipe1;
  end
  assign if3.add_out = pipe2;

  adder_share_arbiter #(.NREQ(4), .ADD_LAT(1), .W(9)) dut1 (
    .clk(clk), .resetn(resetn), .bus(if1), .busy(busy1)
  );
  adder_share_arbiter #(.NREQ(4), .ADD_LAT(3), .W(9)) dut3 (
    .clk(clk), .resetn(resetn), .bus(if3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic drive(input int d, input logic [3:0] r, input logic [35:0] a, input logic [35:0] b);
    if (d == 0) begin
      if1.req = r; if1.req_a = a; if1.req_b = b;
    end else begin
      if3.req = r; if3.req_a = a; if3.req_b = b;
    end
  endtask

  task automatic sample(input int d, output logic [3:0] g, output logic [3:0] v,
                        output logic [9:0] s, output logic [1:0] id, output logic bz,
                        output logic [8:0] i0, output logic [8:0] i1);
    if (d == 0) begin
      g = if1.gnt; v = if1.rsp_valid; s = if1.rsp_sum; id = if1.rsp_id;
      bz = busy1; i0 = if1.add_in0; i1 = if1.add_in1;
    end else begin
      g = if3.gnt; v = if3.rsp_valid; s = if3.rsp_sum; id = if3.rsp_id;
      bz = busy3; i0 = if3.add_in0; i1 = if3.add_in1;
    end
  endtask

  task automatic reset_check(input int d);
    logic [3:0] g, v; logic [9:0] s; logic [1:0] id; logic bz; logic [8:0] i0, i1;
    sample(d, g, v, s, id, bz, i0, i1);
    chk("rst_gnt", 32'(g), 0);
    chk("rst_rsp_valid", 32'(v), 0);
    chk("rst_rsp_sum", 32'(s), 0);
    chk("rst_rsp_id", 32'(id), 0);
    chk("rst_busy", 32'(bz), 0);
    chk("rst_add_in0", 32'(i0), 0);
    chk("rst_add_in1", 32'(i1), 0);
  endtask

  // Starts in an IDLE cycle (at negedge), ends in the following IDLE cycle.
  task automatic op(input int d, input logic [3:0] r, input logic [3:0] r_during,
                    input logic [35:0] a, input logic [35:0] b);
    logic [3:0] g, v, eg; logic [9:0] s, es; logic [1:0] id; logic bz;
    logic [8:0] i0, i1, ea, eb;
    int lat, win;
    lat = (d == 0) ? 1 : 3;
    drive(d, r, a, b);
    if (r == 4'b0) begin
      @(negedge clk);
      sample(d, g, v, s, id, bz, i0, i1);
      chk("idle_gnt", 32'(g), 0);
      chk("idle_busy", 32'(bz), 0);
      return;
    end
    win = pick(r, ptr[d]);
    ptr[d] = (win + 1) % 4;
    ea = a[win*9 +: 9];
    eb = b[win*9 +: 9];
    es = {1'b0, ea} + {1'b0, eb};
    eg = 4'b0001 << win;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      drive(d, (k == 1 && lat > 1) ? 4'b0 : r_during, a, b);
      sample(d, g, v, s, id, bz, i0, i1);
      chk("gnt", 32'(g), (k == 1) ? 32'(eg) : 0);
      chk("rsp_valid", 32'(v), (k == lat + 1) ? 32'(eg) : 0);
      chk("busy", 32'(bz), 1);
      chk("add_in0", 32'(i0), 32'(ea));
      chk("add_in1", 32'(i1), 32'(eb));
      chk("rsp_id", 32'(id), 32'(win));
      if (k == lat + 1) chk("rsp_sum", 32'(s), 32'(es));
    end
    @(negedge clk);
    sample(d, g, v, s, id, bz, i0, i1);
    chk("post_rsp_valid", 32'(v), 0);
    chk("post_busy", 32'(bz), 0);
    chk("hold_rsp_sum", 32'(s), 32'(es));
    chk("hold_rsp_id", 32'(id), 32'(win));
  endtask

  initial begin
    logic [3:0] g, v; logic [9:0] s; logic [1:0] id; logic bz; logic [8:0] i0, i1;
    logic [35:0] ra, rb;
    ptr[0] = 0;
    ptr[1] = 0;
    resetn = 1'b0;
    drive(0, 4'b0, 36'b0, 36'b0);
    drive(1, 4'b0, 36'b0, 36'b0);
    repeat (2) @(negedge clk);
    reset_check(0);
    reset_check(1);
    resetn = 1'b1;
    @(negedge clk);

    // All four requesting: rotation 0,1,2,3,0 with one grant every 3 cycles.
    ra = {9'd40, 9'd30, 9'd20, 9'd10};
    rb = {9'd4, 9'd3, 9'd2, 9'd1};
    repeat (5) op(0, 4'b1111, 4'b1111, ra, rb);

    op(0, 4'b0001, 4'b0000, 36'd5, 36'd7);
    op(0, 4'b0100, 4'b0000, {4{9'd511}}, {4{9'd511}});
    // rr_ptr now 3: 0101 wraps past 3 to requester 0.
    op(0, 4'b0101, 4'b0000, {9'd1, 9'd2, 9'd3, 9'd4}, {9'd9, 9'd8, 9'd7, 9'd6});

    // Reset in the first WAIT cycle discards the operation.
    drive(0, 4'b0100, {9'd100, 9'd200, 9'd300, 9'd400}, 36'd0);
    @(negedge clk);
    sample(0, g, v, s, id, bz, i0, i1);
    chk("pre_rst_gnt", 32'(g), 32'h4);
    resetn = 1'b0;
    #1;
    reset_check(0);
    reset_check(1);
    drive(0, 4'b0, 36'b0, 36'b0);
    @(negedge clk);
    resetn = 1'b1;
    ptr[0] = 0;
    ptr[1] = 0;
    repeat (3) begin
      @(negedge clk);
      sample(0, g, v, s, id, bz, i0, i1);
      chk("after_rst_rsp_valid", 32'(v), 0);
      chk("after_rst_busy", 32'(bz), 0);
    end
    op(0, 4'b1111, 4'b0000, {9'd11, 9'd22, 9'd33, 9'd44}, {9'd55, 9'd66, 9'd77, 9'd88});

    // Latency 3: late request from 0 waits for the next arbitration.
    op(1, 4'b0010, 4'b0001, {9'd0, 9'd0, 9'd123, 9'd17}, {9'd0, 9'd0, 9'd456, 9'd19});
    op(1, 4'b0001, 4'b0000, {9'd0, 9'd0, 9'd123, 9'd17}, {9'd0, 9'd0, 9'd456, 9'd19});

    for (int n = 0; n < 40; n++) begin
      ra = 36'({$urandom(), $urandom()});
      rb = 36'({$urandom(), $urandom()});
      op(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ra, rb);
    end
    drive(0, 4'b0, 36'b0, 36'b0);
    for (int n = 0; n < 15; n++) begin
      ra = 36'({$urandom(), $urandom()});
      rb = 36'({$urandom(), $urandom()});
      op(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ra, rb);
    end
    drive(1, 4'b0, 36'b0, 36'b0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
